// File: rtl/pm_noc_fifo_rd_pkg.sv
// Shared definitions for both halves of the NoC-to-PM asynchronous FIFO:
// default geometry plus the Gray/binary pointer conversions.
package pm_noc_fifo_rd_pkg;

    localparam int NOC_ASYNC_FIFO_AWIDTH      = 3;
    localparam int NOC_ASYNC_FIFO_PACKET_SIZE = 32;
    localparam int PTR_FN_W                   = 32;

    typedef logic [PTR_FN_W-1:0] ptr_word_t;

    // Narrower pointers are zero-extended by the caller; leading zeros convert to zeros.
    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t gray);
        ptr_word_t bin;
        bin = gray;
        for (int i = 1; i < PTR_FN_W; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/pm_noc_fifo_rd_gray_sync.sv
// pm_gray_sync: multi-bit flop chain for a Gray-coded pointer crossing into
// the local clock domain; reusable on the write side for the read pointer.
module pm_gray_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_d [STAGES];

    // Next-state of the chain: stage 0 takes the asynchronous input directly.
    always_comb begin
        sync_d[0] = d_i;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Synchroniser flops with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pm_noc_fifo_rd.sv
// PM-domain read half of the NoC-to-PM asynchronous FIFO: registered packet
// stream, Gray read pointer, fill level. Optional PM_NOC_FIFO_RD_PKTCNT_EN adds a packet counter.
module pm_noc_fifo_rd
    import pm_noc_fifo_rd_pkg::*;
#(
    parameter int AWIDTH      = NOC_ASYNC_FIFO_AWIDTH,
    parameter int PACKET_SIZE = NOC_ASYNC_FIFO_PACKET_SIZE,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk_pm_i,
    input  logic                   reset_pm_n_i,
    input  logic [PACKET_SIZE-1:0] noc_fifo_pm_in_data_i,
    input  logic [AWIDTH:0]        noc_fifo_pm_in_waddr_i,
    output logic [AWIDTH:0]        noc_fifo_pm_in_raddr_o,
    output logic [PACKET_SIZE-1:0] pkt_data_o,
    output logic                   pkt_valid_o,
    input  logic                   pkt_ready_i,
    output logic                   fifo_empty_o,
    output logic [AWIDTH:0]        fifo_level_o,
    output logic [31:0]            pkt_count_o
);

    localparam int PW = AWIDTH + 1;

    logic [PW-1:0]          wsync_gray_s;
    logic [PW-1:0]          wsync_bin_s;
    logic [PW-1:0]          rd_ptr_inc_s;
    logic                   empty_s;
    logic                   load_s;

    logic [PW-1:0]          rd_ptr_bin_q, rd_ptr_bin_d;
    logic [PW-1:0]          raddr_q,      raddr_d;
    logic [PACKET_SIZE-1:0] pkt_data_q,   pkt_data_d;
    logic                   pkt_valid_q,  pkt_valid_d;
    logic [PW-1:0]          level_q,      level_d;

    pm_gray_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk_i   (clk_pm_i),
        .rst_n_i (reset_pm_n_i),
        .d_i     (noc_fifo_pm_in_waddr_i),
        .q_o     (wsync_gray_s)
    );

    assign wsync_bin_s  = PW'(gray2bin(PTR_FN_W'(wsync_gray_s)));
    assign rd_ptr_inc_s = rd_ptr_bin_q + {{(PW-1){1'b0}}, 1'b1};
    assign empty_s      = (raddr_q == wsync_gray_s);
    assign load_s       = !empty_s && (!pkt_valid_q || pkt_ready_i);

    // Output register and read pointer next-state; a stall holds everything.
    always_comb begin
        rd_ptr_bin_d = rd_ptr_bin_q;
        raddr_d      = raddr_q;
        pkt_data_d   = pkt_data_q;
        pkt_valid_d  = pkt_valid_q;
        if (load_s) begin
            pkt_data_d   = noc_fifo_pm_in_data_i;
            pkt_valid_d  = 1'b1;
            rd_ptr_bin_d = rd_ptr_inc_s;
            raddr_d      = PW'(bin2gray(PTR_FN_W'(rd_ptr_inc_s)));
        end else if (pkt_ready_i) begin
            pkt_valid_d  = 1'b0;
        end else begin
            pkt_valid_d  = pkt_valid_q;
        end
    end

    // Modulo subtraction; the extra pointer MSB lets a full FIFO read as 2^AWIDTH.
    always_comb begin
        level_d = wsync_bin_s - rd_ptr_bin_q;
    end

    // Pointer, packet and level flops.
    always_ff @(posedge clk_pm_i or negedge reset_pm_n_i) begin
        if (!reset_pm_n_i) begin
            rd_ptr_bin_q <= {PW{1'b0}};
            raddr_q      <= {PW{1'b0}};
            pkt_data_q   <= {PACKET_SIZE{1'b0}};
            pkt_valid_q  <= 1'b0;
            level_q      <= {PW{1'b0}};
        end else begin
            rd_ptr_bin_q <= rd_ptr_bin_d;
            raddr_q      <= raddr_d;
            pkt_data_q   <= pkt_data_d;
            pkt_valid_q  <= pkt_valid_d;
            level_q      <= level_d;
        end
    end

`ifdef PM_NOC_FIFO_RD_PKTCNT_EN
    logic [31:0] pkt_count_q, pkt_count_d;

    // Counts handshakes; wraps naturally at 32 bits.
    always_comb begin
        if (pkt_valid_q && pkt_ready_i) begin
            pkt_count_d = pkt_count_q + 32'd1;
        end else begin
            pkt_count_d = pkt_count_q;
        end
    end

    // Accepted-packet counter flop.
    always_ff @(posedge clk_pm_i or negedge reset_pm_n_i) begin
        if (!reset_pm_n_i) begin
            pkt_count_q <= 32'h0;
        end else begin
            pkt_count_q <= pkt_count_d;
        end
    end

    assign pkt_count_o = pkt_count_q;
`else
    assign pkt_count_o = 32'h0;
`endif

    assign noc_fifo_pm_in_raddr_o = raddr_q;
    assign pkt_data_o             = pkt_data_q;
    assign pkt_valid_o            = pkt_valid_q;
    assign fifo_level_o           = level_q;
    assign fifo_empty_o           = empty_s;

endmodule

// File: tb/tb_pm_noc_fifo_rd.sv
// Randomised bench for pm_noc_fifo_rd against an integer-pointer model of the FIFO read side.
module tb_pm_noc_fifo_rd;

    localparam int AW    = 3;
    localparam int PS    = 32;
    localparam int SS    = 2;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 8;
    localparam int PMOD  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [PS-1:0] data_in;
    logic [PW-1:0] waddr = 4'd0;
    logic [PW-1:0] raddr;
    logic [PS-1:0] pkt_data;
    logic          pkt_valid;
    logic          ready = 1'b0;
    logic          empty;
    logic [PW-1:0] level;
    logic [31:0]   cnt;

    logic [PS-1:0] mem [DEPTH];

    always #5 clk = ~clk;

    function automatic int g2b(input int g);
        int b;
        b = g;
        for (int s = 1; s < PW; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic int b2g(input int b);
        int m;
        m = b % PMOD;
        return m ^ (m >> 1);
    endfunction

    // NoC-side half: entry at the current read pointer.
    assign data_in = mem[3'(g2b(int'(raddr)))];

    pm_noc_fifo_rd #(.AWIDTH(AW), .PACKET_SIZE(PS), .SYNC_STAGES(SS)) dut (
        .clk_pm_i               (clk),
        .reset_pm_n_i           (rst_n),
        .noc_fifo_pm_in_data_i  (data_in),
        .noc_fifo_pm_in_waddr_i (waddr),
        .noc_fifo_pm_in_raddr_o (raddr),
        .pkt_data_o             (pkt_data),
        .pkt_valid_o            (pkt_valid),
        .pkt_ready_i            (ready),
        .fifo_empty_o           (empty),
        .fifo_level_o           (level),
        .pkt_count_o            (cnt)
    );

    // Model state: unbounded integer pointers, waddr history for the sync delay.
    int            wq [SS];
    int            m_rd;
    int            wptr;
    bit            m_valid;
    logic [PS-1:0] m_data;
    int            m_level;
    int unsigned   m_count;
    int unsigned   n_acc;
    logic [PS-1:0] expq [$];
    logic [PW-1:0] prev_raddr;
    int            n_cmp = 0;
    int            n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SS; i++) wq[i] = 0;
        m_rd = 0; wptr = 0; m_valid = 1'b0; m_data = '0;
        m_level = 0; m_count = 0; n_acc = 0;
        expq.delete();
        prev_raddr = '0;
    endtask

    task automatic compare_model();
        chk("raddr", raddr, b2g(m_rd));
        chk("valid", pkt_valid, m_valid);
        if (m_valid) chk("data", pkt_data, m_data);
        chk("empty", empty, (b2g(m_rd) == wq[SS-1]) ? 1 : 0);
        chk("level", level, m_level);
        chk("count", cnt, m_count);
        chk("gray_step", ($countones(raddr ^ prev_raddr) <= 1) ? 1 : 0, 1);
        prev_raddr = raddr;
    endtask

    // One clock: check, drive inputs, advance the model, move to the next negedge.
    task automatic tick(input bit rdy, input bit wr, input logic [PS-1:0] wd, output bit wrote);
        int  ws;
        bit  load;
        int  nlevel;
        compare_model();
        ready = rdy;
        wrote = 1'b0;
        if (wr && (wptr - m_rd) < DEPTH) begin
            mem[wptr % DEPTH] = wd;
            expq.push_back(wd);
            wptr++;
            waddr = PW'(b2g(wptr));
            wrote = 1'b1;
        end
        if (pkt_valid && rdy) begin
            if (expq.size() == 0) chk("order_underflow", 1, 0);
            else chk("order", pkt_data, expq.pop_front());
        end
        ws     = g2b(wq[SS-1]);
        load   = (ws != m_rd % PMOD) && (!m_valid || rdy);
        nlevel = (ws - (m_rd % PMOD) + PMOD) % PMOD;
        if (m_valid && rdy) begin
            n_acc++;
`ifdef PM_NOC_FIFO_RD_PKTCNT_EN
            m_count++;
`endif
        end
        if (load) begin
            m_data  = mem[m_rd % DEPTH];
            m_valid = 1'b1;
            m_rd++;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        m_level = nlevel;
        for (int i = SS - 1; i > 0; i--) wq[i] = wq[i-1];
        wq[0] = int'(waddr);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit            w;
        logic [PS-1:0] fill_first;
        int            pushed;
        int            acc0;
        int            guard;

        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_raddr", raddr, 0);
        chk("rst_valid", pkt_valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_level", level, 0);
        chk("rst_count", cnt, 0);
        rst_n = 1'b1;

        // Single packet: visible three clocks after the pointer moves.
        tick(1'b1, 1'b1, 32'hA5, w);
        tick(1'b1, 1'b0, 32'h0, w);
        chk("a5_not_empty", empty, 0);
        chk("a5_valid_early", pkt_valid, 0);
        tick(1'b1, 1'b0, 32'h0, w);
        chk("a5_valid", pkt_valid, 1);
        chk("a5_data", pkt_data, 32'hA5);
        chk("a5_raddr", raddr, 4'b0001);
        chk("a5_empty_again", empty, 1);
        tick(1'b1, 1'b0, 32'h0, w);
        chk("a5_drained", pkt_valid, 0);

        // Fill eight entries with the consumer stalled.
        for (int i = 0; i < DEPTH; i++) begin
            logic [PS-1:0] d;
            d = $urandom;
            if (i == 0) fill_first = d;
            tick(1'b0, 1'b1, d, w);
            chk("fill_accepted", w, 1);
        end
        repeat (4) tick(1'b0, 1'b0, 32'h0, w);
        chk("fill_level", level, 7);
        chk("fill_valid", pkt_valid, 1);
        chk("fill_head", pkt_data, fill_first);
        acc0 = n_acc;
        for (int i = 0; i < DEPTH; i++) begin
            chk("burst_no_bubble", pkt_valid, 1);
            tick(1'b1, 1'b0, 32'h0, w);
        end
        chk("burst_count", n_acc - acc0, DEPTH);
        chk("burst_valid_end", pkt_valid, 0);
        chk("burst_empty_end", empty, 1);
        chk("burst_level_end", level, 0);

        // Twenty packets through, wrapping the pointers.
        pushed = 0; acc0 = n_acc; guard = 0;
        while ((n_acc - acc0) < 20 && guard < 200) begin
            tick(1'b1, pushed < 20, $urandom, w);
            if (w) pushed++;
            guard++;
        end
        chk("push20_done", n_acc - acc0, 20);
`ifdef PM_NOC_FIFO_RD_PKTCNT_EN
        chk("push20_cnt", cnt, n_acc);
`else
        chk("push20_cnt", cnt, 0);
`endif

        // Random ready and writer activity.
        for (int i = 0; i < 1500; i++) begin
            tick($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, $urandom, w);
        end

        // Asynchronous reset with entries pending.
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, $urandom, w);
        repeat (4) tick(1'b0, 1'b0, 32'h0, w);
        chk("pre_rst_valid", pkt_valid, 1);
        #2;
        rst_n = 1'b0;
        waddr = '0;
        #1;
        chk("arst_valid", pkt_valid, 0);
        chk("arst_raddr", raddr, 0);
        chk("arst_data", pkt_data, 0);
        chk("arst_empty", empty, 1);
        chk("arst_level", level, 0);
        chk("arst_count", cnt, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 500; i++) begin
            tick($urandom_range(0, 9) < 5, $urandom_range(0, 9) < 7, $urandom, w);
        end
        compare_model();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
